instr_fetch_ctrl: RTL and testbench
===================================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, 10, PC and instruction-memory address width.
REQ-002 Parameter DATA_W, 32, instruction width.
REQ-003 Parameter TIMEOUT, 16, maximum FETCH cycles without imem_ack before error.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_req  out  1  fetch request, held high until imem_ack.
REQ-007 imem_addr  out  ADDR_W  fetch address, equal to pc while imem_req is high.
REQ-008 imem_ack  in  1  one-cycle completion strobe; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  in  DATA_W  fetched instruction word.
REQ-010 instr  out  DATA_W  buffered instruction to decode.
REQ-011 instr_pc  out  ADDR_W  address of instr.
REQ-012 instr_valid  out  1  instr is offered to decode.
REQ-013 instr_ready  in  1  decode accepts; a transfer occurs when instr_valid && instr_ready.
REQ-014 stall  in  1  back-end hazard hold.
REQ-015 redirect_valid  in  1  one-cycle branch/jump redirect strobe.
REQ-016 redirect_target  in  ADDR_W  new PC (pc+imm for B-type/jal, rs1+imm for jalr).
REQ-017 pc  out  ADDR_W  next fetch address.
REQ-018 misalign  out  1  one-cycle pulse: redirect_target[1:0] != 0.
REQ-019 fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-020 States: IDLE, FETCH, HOLD, ERR; transitions only on rising clk.
REQ-021 IDLE: outputs inactive; unconditionally enter FETCH on the next cycle.
REQ-022 FETCH: imem_req=1, imem_addr=pc; stall has no effect.
REQ-023 FETCH + imem_ack + no pending drop: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, enter HOLD; latency from req to instr_valid is ack cycle + 1.
REQ-024 FETCH + redirect_valid: set drop flag, latch target; imem_req stays high until ack.
REQ-025 FETCH + imem_ack + drop flag, or redirect in the ack cycle: discard data, pc<=target, clear drop, remain in FETCH with a new request from the next cycle.
REQ-026 HOLD: instr_valid = !stall; on transfer, enter FETCH next cycle.
REQ-027 HOLD + stall: remain in HOLD with instr unchanged.
REQ-028 HOLD + redirect_valid: pc<=target, instr_valid low from the next cycle, enter FETCH; any transfer in the same cycle still counts as consumed.
REQ-029 redirect_valid overrides stall in all states except ERR and IDLE, where it is ignored.
REQ-030 Redirect alignment: target[1:0] is forced to 00 when loaded; misalign pulses high in the redirect cycle +1.
REQ-031 PC arithmetic is modulo 2^ADDR_W: 0x3FC+4 -> 0x000, with no flag.
REQ-032 Timeout counter clears on entry to FETCH and on each ack, and increments on every FETCH cycle without ack; reaching TIMEOUT enters ERR.
REQ-033 ERR: imem_req=0, instr_valid=0, fetch_err=1; exit only via reset.

Reset
REQ-034 Reset sets state=IDLE, pc=0, instr=0, instr_pc=0, imem_req=0, instr_valid=0, misalign=0, fetch_err=0, clears the drop flag, and clears the timeout counter.
REQ-035 Reset asserted mid-fetch abandons the transaction; an imem_ack arriving after reset release while in IDLE is ignored.

Structure
REQ-036 A shared package holds the state enum, PC_INC=4, and the ADDR_W, DATA_W and TIMEOUT defaults.
REQ-037 One sub-module, fetch_timeout_ctr, provides clear, inc and expired; all other logic is in instr_fetch_ctrl.

Verification
REQ-038 Reset release, ack 2 cycles after req with rdata=0x00500093, ready=1 -> instr_pc=0x000, instr=0x00500093, then imem_addr=0x004.
REQ-039 instr_valid held, stall=1 for 3 cycles, ready=1 -> instr_valid low for 3 cycles, transfer on cycle 4, instr unchanged.
REQ-040 redirect_target=0x040 while FETCH awaits ack -> rdata of the old fetch is discarded; the next request is at 0x040.
REQ-041 redirect_target=0x043 in HOLD -> misalign pulses once; next fetch at 0x040.
REQ-042 pc=0x3FC, ack -> next imem_addr=0x000.
REQ-043 No ack for 16 FETCH cycles -> fetch_err=1, imem_req=0, redirect ignored; reset clears fetch_err.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared fetch-controller types and defaults
// Contents: fetch_state_t FSM encoding, PC_INC step, ADDR_W/DATA_W/TIMEOUT defaults.
package instr_fetch_ctrl_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;
    localparam int PC_INC      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - fetch controller bus bundle (imem, decode, redirect, status)
// master: fetch controller side (drives imem_req/imem_addr, instr*, pc, misalign, fetch_err)
// slave : environment side (drives imem_ack/imem_rdata, instr_ready, stall, redirect_*)
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = instr_fetch_ctrl_pkg::ADDR_W_DEF,
    parameter int DATA_W = instr_fetch_ctrl_pkg::DATA_W_DEF
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] pc;
    logic              misalign;
    logic              fetch_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr, instr_pc, instr_valid,
        input  instr_ready, stall, redirect_valid, redirect_target,
        output pc, misalign, fetch_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr, instr_pc, instr_valid,
        output instr_ready, stall, redirect_valid, redirect_target,
        input  pc, misalign, fetch_err
    );

endinterface

// File: rtl/instr_fetch_ctrl_fetch_timeout_ctr.sv
// rtl/instr_fetch_ctrl_fetch_timeout_ctr.sv - counts FETCH cycles without imem_ack
// Ports: clk, reset (sync, active-high), clear, inc, expired (this inc reaches TIMEOUT).
module fetch_timeout_ctr #(
    parameter int TIMEOUT = instr_fetch_ctrl_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    import instr_fetch_ctrl_pkg::*;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Flags the increment that would make the count equal TIMEOUT, so the
    // owner leaves FETCH after exactly TIMEOUT unanswered cycles.
    assign expired = inc && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch controller with redirect, stall hold and timeout
// Ports: clk, reset (sync, active-high), bus (instr_fetch_ctrl_if.master): imem request/ack,
//        decode valid/ready, stall, redirect, pc, misalign pulse, sticky fetch_err.
module instr_fetch_ctrl #(
    parameter int ADDR_W  = instr_fetch_ctrl_pkg::ADDR_W_DEF,
    parameter int DATA_W  = instr_fetch_ctrl_pkg::DATA_W_DEF,
    parameter int TIMEOUT = instr_fetch_ctrl_pkg::TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_ctrl_if.master bus
);
    import instr_fetch_ctrl_pkg::*;

    fetch_state_t      state, next_state;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] drop_tgt_q;
    logic              drop_q;
    logic              misalign_q;

    logic [ADDR_W-1:0] redir_al;
    logic [ADDR_W-1:0] pc_tgt;
    logic              instr_valid_c;
    logic              transfer;
    logic              redir_ok;
    logic              take_data;
    logic              load_pc;
    logic              set_drop;
    logic              clr_drop;
    logic              tmo_clear;
    logic              tmo_inc;
    logic              tmo_expired;

    assign redir_al      = {bus.redirect_target[ADDR_W-1:2], 2'b00};
    assign instr_valid_c = (state == HOLD) && !bus.stall;
    assign transfer      = instr_valid_c && bus.instr_ready;
    // Redirects are only honoured while the pipeline is live.
    assign redir_ok      = bus.redirect_valid && ((state == FETCH) || (state == HOLD));

    // Idle/hold/err keep the counter at zero, so every entry into FETCH starts fresh.
    assign tmo_clear = (state != FETCH) || bus.imem_ack;
    assign tmo_inc   = (state == FETCH) && !bus.imem_ack;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        take_data  = 1'b0;
        load_pc    = 1'b0;
        pc_tgt     = redir_al;
        set_drop   = 1'b0;
        clr_drop   = 1'b0;
        case (state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid || drop_q) begin
                        // Stale word: steer to the newest target and re-request.
                        load_pc  = 1'b1;
                        pc_tgt   = bus.redirect_valid ? redir_al : drop_tgt_q;
                        clr_drop = 1'b1;
                    end else begin
                        take_data  = 1'b1;
                        next_state = HOLD;
                    end
                end else begin
                    // The outstanding request cannot be withdrawn; remember
                    // the target and throw its data away when it lands.
                    set_drop = bus.redirect_valid;
                    if (tmo_expired) begin
                        next_state = ERR;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    load_pc    = 1'b1;
                    next_state = FETCH;
                end else if (transfer) begin
                    next_state = FETCH;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            drop_q     <= 1'b0;
            drop_tgt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redir_ok && (bus.redirect_target[1:0] != 2'b00);
            if (take_data) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc_q;
                pc_q       <= pc_q + ADDR_W'(PC_INC);
            end else if (load_pc) begin
                pc_q <= pc_tgt;
            end
            if (clr_drop) begin
                drop_q <= 1'b0;
            end else if (set_drop) begin
                drop_q     <= 1'b1;
                drop_tgt_q <= redir_al;
            end
        end
    end

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_c;
    assign bus.pc          = pc_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_err   = (state == ERR);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    instr_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "woken" = first cycle after reset, "req" = request
    // outstanding, "full" = word buffered for decode, "dead" = timed out.
    bit          m_synced = 0;
    bit          m_wake, m_req, m_full, m_dead, m_drop, m_mis;
    int          m_pc, m_ipc, m_tgt, m_wait;
    logic [31:0] m_instr;

    task automatic model_step();
        int  tgt_al;
        bit  redir, mis_n;
        if (reset) begin
            m_wake = 1; m_req = 0; m_full = 0; m_dead = 0; m_drop = 0; m_mis = 0;
            m_pc = 0; m_ipc = 0; m_tgt = 0; m_wait = 0; m_instr = 0;
            return;
        end
        redir  = bus.redirect_valid && (m_req || m_full);
        tgt_al = int'(bus.redirect_target) & ~3;
        mis_n  = redir && ((int'(bus.redirect_target) % 4) != 0);
        if (m_wake) begin
            m_wake = 0; m_req = 1; m_wait = 0;
        end else if (m_req) begin
            if (bus.imem_ack) begin
                m_wait = 0;
                if (bus.redirect_valid || m_drop) begin
                    m_pc   = bus.redirect_valid ? tgt_al : m_tgt;
                    m_drop = 0;
                end else begin
                    m_instr = bus.imem_rdata;
                    m_ipc   = m_pc;
                    m_pc    = (m_pc + 4) % 1024;
                    m_req   = 0;
                    m_full  = 1;
                end
            end else begin
                if (bus.redirect_valid) begin
                    m_drop = 1;
                    m_tgt  = tgt_al;
                end
                m_wait++;
                if (m_wait == TMO) begin
                    m_req  = 0;
                    m_dead = 1;
                end
            end
        end else if (m_full) begin
            if (bus.redirect_valid) begin
                m_pc = tgt_al; m_full = 0; m_req = 1; m_wait = 0;
            end else if (!bus.stall && bus.instr_ready) begin
                m_full = 0; m_req = 1; m_wait = 0;
            end
        end
        m_mis = mis_n;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_synced) begin
                chk("m_imem_req", bus.imem_req, m_req);
                if (m_req) chk("m_imem_addr", bus.imem_addr, m_pc);
                chk("m_pc", bus.pc, m_pc);
                chk("m_instr_valid", bus.instr_valid, m_full && !bus.stall);
                chk("m_instr", bus.instr, m_instr);
                chk("m_instr_pc", bus.instr_pc, m_ipc);
                chk("m_misalign", bus.misalign, m_mis);
                chk("m_fetch_err", bus.fetch_err, m_dead);
            end
            model_step();
            m_synced = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.imem_ack        = 0;
        bus.imem_rdata      = '0;
        bus.instr_ready     = 0;
        bus.stall           = 0;
        bus.redirect_valid  = 0;
        bus.redirect_target = '0;
        repeat (3) tick();

        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_misalign", bus.misalign, 0);
        chk("rst_fetch_err", bus.fetch_err, 0);

        // First fetch, ack two cycles after request.
        reset = 0;
        bus.instr_ready = 1;
        n = 0;
        while (!bus.imem_req && n < 8) begin
            tick();
            n++;
        end
        chk("first_req_seen", bus.imem_req, 1);
        tick();
        tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'h00500093;
        tick();
        bus.imem_ack = 0;
        chk("f1_valid", bus.instr_valid, 1);
        chk("f1_instr", bus.instr, 32'h00500093);
        chk("f1_instr_pc", bus.instr_pc, 0);
        tick();
        chk("f1_next_req", bus.imem_req, 1);
        chk("f1_next_addr", bus.imem_addr, 10'h004);

        // Stall hold for three cycles.
        bus.imem_ack = 1; bus.imem_rdata = 32'h00A00113;
        tick();
        bus.imem_ack = 0; bus.stall = 1;
        #1 chk("stall_v0", bus.instr_valid, 0);
        tick();
        chk("stall_v1", bus.instr_valid, 0);
        tick();
        chk("stall_v2", bus.instr_valid, 0);
        bus.stall = 0;
        #1 chk("stall_release_valid", bus.instr_valid, 1);
        chk("stall_instr", bus.instr, 32'h00A00113);
        chk("stall_instr_pc", bus.instr_pc, 10'h004);
        tick();
        chk("stall_next_addr", bus.imem_addr, 10'h008);

        // Redirect while the fetch is outstanding drops the old word.
        bus.redirect_valid = 1; bus.redirect_target = 10'h040;
        tick();
        bus.redirect_valid = 0;
        chk("drop_req_held", bus.imem_req, 1);
        chk("drop_addr_held", bus.imem_addr, 10'h008);
        tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'hDEADBEEF;
        tick();
        bus.imem_ack = 0;
        chk("drop_valid", bus.instr_valid, 0);
        chk("drop_new_addr", bus.imem_addr, 10'h040);
        bus.imem_ack = 1; bus.imem_rdata = 32'h11111111;
        tick();
        bus.imem_ack = 0;
        chk("drop_instr", bus.instr, 32'h11111111);
        chk("drop_instr_pc", bus.instr_pc, 10'h040);
        tick();

        // Misaligned redirect in HOLD.
        bus.instr_ready = 0;
        bus.imem_ack = 1; bus.imem_rdata = 32'h22222222;
        tick();
        bus.imem_ack = 0;
        bus.redirect_valid = 1; bus.redirect_target = 10'h043;
        tick();
        bus.redirect_valid = 0;
        chk("mis_pulse", bus.misalign, 1);
        chk("mis_addr", bus.imem_addr, 10'h040);
        chk("mis_valid", bus.instr_valid, 0);
        tick();
        chk("mis_once", bus.misalign, 0);

        // Redirect in the ack cycle to the top of memory, then wrap.
        bus.redirect_valid = 1; bus.redirect_target = 10'h3FC;
        bus.imem_ack = 1; bus.imem_rdata = 32'h55555555;
        tick();
        bus.redirect_valid = 0; bus.imem_ack = 0;
        chk("wrap_addr", bus.imem_addr, 10'h3FC);
        bus.imem_ack = 1; bus.imem_rdata = 32'h33333333;
        tick();
        bus.imem_ack = 0;
        chk("wrap_instr_pc", bus.instr_pc, 10'h3FC);
        chk("wrap_pc", bus.pc, 10'h000);
        bus.instr_ready = 1;
        tick();
        chk("wrap_next_addr", bus.imem_addr, 10'h000);

        // Timeout: 16 unanswered FETCH cycles.
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_req_high", bus.imem_req, 1);
            tick();
        end
        chk("tmo_fetch_err", bus.fetch_err, 1);
        chk("tmo_req_low", bus.imem_req, 0);
        bus.redirect_valid = 1; bus.redirect_target = 10'h101;
        tick();
        bus.redirect_valid = 0;
        chk("err_redirect_pc", bus.pc, 10'h000);
        chk("err_no_misalign", bus.misalign, 0);
        chk("err_sticky", bus.fetch_err, 1);
        reset = 1;
        tick();
        chk("err_cleared", bus.fetch_err, 0);

        // Reset mid-fetch, then a stray ack during IDLE.
        reset = 0;
        tick();
        chk("mid_req", bus.imem_req, 1);
        reset = 1;
        tick();
        reset = 0;
        bus.imem_ack = 1; bus.imem_rdata = 32'h44444444;
        tick();
        bus.imem_ack = 0;
        chk("stray_instr", bus.instr, 0);
        chk("stray_req", bus.imem_req, 1);
        chk("stray_addr", bus.imem_addr, 10'h000);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
